// File: rtl/eth_mac_pkg.sv
// Shared constants, FSM state types and width helpers for the eth_mac RX/TX datapaths.
package eth_mac_pkg;

  localparam int PKT_LEN_W   = 16;
  localparam int UDP_CS_W    = 16;
  localparam int BLOCK_N     = 8;
  localparam int BLOCK_LEN_W = $clog2(BLOCK_N + 1);

  // Preamble tail: 0x55 in every lower byte, SFD 0xD5 in the top byte.
  localparam logic [15:0] START_PATTERN = 16'hD555;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_DATA
  } rx_state_t;

  function automatic int lane0_cnt(input int data_w);
    return (data_w == 64) ? 2 : 1;
  endfunction

endpackage

// File: rtl/eth_mac_rx.sv
// RX deframer: strips the start beat, forwards data beats and trims the terminate beat by its keep mask.
module eth_mac_rx
  import eth_mac_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LEN_W       = $clog2(KEEP_W + 1),
  parameter int LANE0_CNT_N = lane0_cnt(DATA_W)
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   mac_valid_i,
  input  logic                   mac_cancel_i,
  input  logic [DATA_W-1:0]      mac_data_i,
  input  logic                   mac_ctrl_v_i,
  input  logic                   mac_idle_i,
  input  logic [LANE0_CNT_N-1:0] mac_start_i,
  input  logic                   mac_term_i,
  input  logic [KEEP_W-1:0]      mac_term_keep_i,
  output logic                   app_valid_o,
  output logic                   app_cancel_o,
  output logic [DATA_W-1:0]      app_data_o,
  output logic [LEN_W-1:0]       app_len_o
);

  rx_state_t         state_q, state_d;
  logic              valid_d, cancel_d;
  logic [DATA_W-1:0] data_d, term_data;
  logic [LEN_W-1:0]  len_d, term_cnt;

  always_comb begin
    term_data = '0;
    term_cnt  = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      term_data[i*8 +: 8] = mac_term_keep_i[i] ? mac_data_i[i*8 +: 8] : 8'h00;
      term_cnt            = term_cnt + LEN_W'(mac_term_keep_i[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    cancel_d = 1'b0;
    data_d   = '0;
    len_d    = '0;
    if (mac_valid_i) begin
      case (state_q)
        RX_IDLE: if (mac_start_i[0]) state_d = RX_DATA;
        RX_DATA: begin
          if (mac_cancel_i) begin
            cancel_d = 1'b1;
            state_d  = RX_IDLE;
          end else if (mac_start_i[0]) begin
            // A fresh start mid-frame abandons the old frame and keeps receiving.
            cancel_d = 1'b1;
          end else if (mac_term_i) begin
            valid_d = (term_cnt != '0);
            data_d  = term_data;
            len_d   = term_cnt;
            state_d = RX_IDLE;
          end else if (!mac_ctrl_v_i) begin
            valid_d = 1'b1;
            data_d  = mac_data_i;
            len_d   = LEN_W'(KEEP_W);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q      <= RX_IDLE;
      app_valid_o  <= 1'b0;
      app_cancel_o <= 1'b0;
      app_data_o   <= '0;
      app_len_o    <= '0;
    end else begin
      state_q      <= state_d;
      app_valid_o  <= valid_d;
      app_cancel_o <= cancel_d;
      app_data_o   <= data_d;
      app_len_o    <= len_d;
    end
  end

  logic unused_rx;
  assign unused_rx = ^{mac_idle_i, mac_start_i};

endmodule

// File: rtl/eth_mac_tx.sv
// TX framer: turns app beats into start / data / terminate PHY beats, stalled by phy_ready_i.
module eth_mac_tx
  import eth_mac_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int LEN_W          = $clog2(KEEP_W + 1),
  parameter int APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1),
  parameter int LANE0_CNT_N    = lane0_cnt(DATA_W)
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      app_early_v_i,
  input  logic                      app_cancel_i,
  input  logic [DATA_W-1:0]         app_data_i,
  input  logic [LEN_W-1:0]          app_len_i,
  input  logic [PKT_LEN_W-1:0]      app_pkt_len_i,
  input  logic [UDP_CS_W-1:0]       app_cs_i,
  input  logic                      app_last_i,
  input  logic                      app_last_block_next_i,
  input  logic [APP_LAST_LEN_W-1:0] app_last_block_next_len_i,
  input  logic                      phy_ready_i,
  output logic                      app_ready_v_o,
  output logic                      phy_ctrl_v_o,
  output logic [DATA_W-1:0]         phy_data_o,
  output logic [LANE0_CNT_N-1:0]    phy_start_o,
  output logic                      phy_idle_o,
  output logic                      phy_term_o,
  output logic [BLOCK_LEN_W-1:0]    phy_term_len_o
);

  tx_state_t                state_q, state_d;
  logic                     ctrl_v_d, idle_d, term_d;
  logic [DATA_W-1:0]        data_d;
  logic [LANE0_CNT_N-1:0]   start_d;
  logic [BLOCK_LEN_W-1:0]   term_len_d;
  logic [PKT_LEN_W-1:0]     pkt_len_q, pkt_len_d;
  logic [DATA_W-1:0]        start_beat;
  logic [DATA_W-1:0]        last_data;

  always_comb begin
    start_beat = '0;
    last_data  = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      start_beat[i*8 +: 8] = (i == KEEP_W - 1) ? START_PATTERN[15:8] : START_PATTERN[7:0];
      last_data[i*8 +: 8]  = (LEN_W'(i) < app_len_i) ? app_data_i[i*8 +: 8] : 8'h00;
    end
  end

  // Only the idle state offers the handshake; reset holds it off.
  assign app_ready_v_o = phy_ready_i && (state_q == TX_IDLE) && !nreset;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    state_d    = state_q;
    pkt_len_d  = pkt_len_q;
    ctrl_v_d   = phy_ctrl_v_o;
    data_d     = phy_data_o;
    start_d    = phy_start_o;
    idle_d     = phy_idle_o;
    term_d     = phy_term_o;
    term_len_d = phy_term_len_o;
    if (phy_ready_i) begin
      start_d    = '0;
      term_len_d = '0;
      term_d     = 1'b0;
      case (state_q)
        TX_IDLE: begin
          ctrl_v_d = 1'b1;
          idle_d   = 1'b1;
          data_d   = '0;
          if (app_early_v_i) begin
            pkt_len_d  = app_pkt_len_i;
            idle_d     = 1'b0;
            start_d[0] = 1'b1;
            data_d     = start_beat;
            state_d    = TX_START;
          end
        end
        TX_START, TX_DATA: begin
          ctrl_v_d = 1'b0;
          idle_d   = 1'b0;
          data_d   = app_data_i;
          state_d  = TX_DATA;
          if (app_cancel_i) begin
            ctrl_v_d = 1'b1;
            term_d   = 1'b1;
            data_d   = '0;
            state_d  = TX_IDLE;
          end else if (app_last_i) begin
            ctrl_v_d   = 1'b1;
            term_d     = 1'b1;
            term_len_d = BLOCK_LEN_W'(app_len_i);
            data_d     = last_data;
            state_d    = TX_IDLE;
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (nreset) begin
      state_q        <= TX_IDLE;
      pkt_len_q      <= '0;
      phy_ctrl_v_o   <= 1'b1;
      phy_data_o     <= '0;
      phy_start_o    <= '0;
      phy_idle_o     <= 1'b1;
      phy_term_o     <= 1'b0;
      phy_term_len_o <= '0;
    end else begin
      state_q        <= state_d;
      pkt_len_q      <= pkt_len_d;
      phy_ctrl_v_o   <= ctrl_v_d;
      phy_data_o     <= data_d;
      phy_start_o    <= start_d;
      phy_idle_o     <= idle_d;
      phy_term_o     <= term_d;
      phy_term_len_o <= term_len_d;
    end
  end

  // Reserved sideband inputs and the latched packet length have no effect yet.
  logic unused_tx;
  assign unused_tx = ^{app_cs_i, app_last_block_next_i, app_last_block_next_len_i, pkt_len_q};

endmodule

// File: rtl/eth_mac.sv
// Ethernet MAC wrapper: independent RX deframer and TX framer sharing one clock and reset.
module eth_mac
  import eth_mac_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int LEN_W          = $clog2(KEEP_W + 1),
  parameter int APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1),
  parameter int LANE0_CNT_N    = lane0_cnt(DATA_W)
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      mac_valid_i,
  input  logic                      mac_cancel_i,
  input  logic [DATA_W-1:0]         mac_data_i,
  input  logic                      mac_ctrl_v_i,
  input  logic                      mac_idle_i,
  input  logic [LANE0_CNT_N-1:0]    mac_start_i,
  input  logic                      mac_term_i,
  input  logic [KEEP_W-1:0]         mac_term_keep_i,
  output logic                      app_valid_o,
  output logic                      app_cancel_o,
  output logic [DATA_W-1:0]         app_data_o,
  output logic [LEN_W-1:0]          app_len_o,
  input  logic                      app_early_v_i,
  input  logic                      app_cancel_i,
  input  logic [DATA_W-1:0]         app_data_i,
  input  logic [LEN_W-1:0]          app_len_i,
  input  logic [PKT_LEN_W-1:0]      app_pkt_len_i,
  input  logic [UDP_CS_W-1:0]       app_cs_i,
  input  logic                      app_last_i,
  input  logic                      app_last_block_next_i,
  input  logic [APP_LAST_LEN_W-1:0] app_last_block_next_len_i,
  input  logic                      phy_ready_i,
  output logic                      app_ready_v_o,
  output logic                      phy_ctrl_v_o,
  output logic [DATA_W-1:0]         phy_data_o,
  output logic [LANE0_CNT_N-1:0]    phy_start_o,
  output logic                      phy_idle_o,
  output logic                      phy_term_o,
  output logic [BLOCK_LEN_W-1:0]    phy_term_len_o
);

  eth_mac_rx #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W), .LANE0_CNT_N(LANE0_CNT_N)
  ) u_rx (
    .clk(clk), .nreset(nreset),
    .mac_valid_i(mac_valid_i), .mac_cancel_i(mac_cancel_i), .mac_data_i(mac_data_i),
    .mac_ctrl_v_i(mac_ctrl_v_i), .mac_idle_i(mac_idle_i), .mac_start_i(mac_start_i),
    .mac_term_i(mac_term_i), .mac_term_keep_i(mac_term_keep_i),
    .app_valid_o(app_valid_o), .app_cancel_o(app_cancel_o),
    .app_data_o(app_data_o), .app_len_o(app_len_o)
  );

  eth_mac_tx #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W),
    .APP_LAST_LEN_W(APP_LAST_LEN_W), .LANE0_CNT_N(LANE0_CNT_N)
  ) u_tx (
    .clk(clk), .nreset(nreset),
    .app_early_v_i(app_early_v_i), .app_cancel_i(app_cancel_i), .app_data_i(app_data_i),
    .app_len_i(app_len_i), .app_pkt_len_i(app_pkt_len_i), .app_cs_i(app_cs_i),
    .app_last_i(app_last_i), .app_last_block_next_i(app_last_block_next_i),
    .app_last_block_next_len_i(app_last_block_next_len_i), .phy_ready_i(phy_ready_i),
    .app_ready_v_o(app_ready_v_o), .phy_ctrl_v_o(phy_ctrl_v_o), .phy_data_o(phy_data_o),
    .phy_start_o(phy_start_o), .phy_idle_o(phy_idle_o), .phy_term_o(phy_term_o),
    .phy_term_len_o(phy_term_len_o)
  );

endmodule

// File: tb/tb_eth_mac.sv
// Self-checking bench for eth_mac: RX vector table plus hand-written TX and reset sequences, scoreboard-compared.
module tb_eth_mac;

  localparam int DATA_W = 16;
  localparam int KEEP_W = 2;
  localparam int LEN_W  = 2;

  logic        clk = 1'b0;
  logic        nreset;
  logic        mac_valid_i, mac_cancel_i, mac_ctrl_v_i, mac_idle_i, mac_term_i;
  logic [15:0] mac_data_i;
  logic [0:0]  mac_start_i;
  logic [1:0]  mac_term_keep_i;
  logic        app_valid_o, app_cancel_o;
  logic [15:0] app_data_o;
  logic [1:0]  app_len_o;
  logic        app_early_v_i, app_cancel_i, app_last_i, app_last_block_next_i, phy_ready_i;
  logic [15:0] app_data_i, app_pkt_len_i, app_cs_i;
  logic [1:0]  app_len_i;
  logic [3:0]  app_last_block_next_len_i;
  logic        app_ready_v_o, phy_ctrl_v_o, phy_idle_o, phy_term_o;
  logic [15:0] phy_data_o;
  logic [0:0]  phy_start_o;
  logic [3:0]  phy_term_len_o;

  eth_mac #(.DATA_W(DATA_W)) dut (
    .clk(clk), .nreset(nreset),
    .mac_valid_i(mac_valid_i), .mac_cancel_i(mac_cancel_i), .mac_data_i(mac_data_i),
    .mac_ctrl_v_i(mac_ctrl_v_i), .mac_idle_i(mac_idle_i), .mac_start_i(mac_start_i),
    .mac_term_i(mac_term_i), .mac_term_keep_i(mac_term_keep_i),
    .app_valid_o(app_valid_o), .app_cancel_o(app_cancel_o),
    .app_data_o(app_data_o), .app_len_o(app_len_o),
    .app_early_v_i(app_early_v_i), .app_cancel_i(app_cancel_i), .app_data_i(app_data_i),
    .app_len_i(app_len_i), .app_pkt_len_i(app_pkt_len_i), .app_cs_i(app_cs_i),
    .app_last_i(app_last_i), .app_last_block_next_i(app_last_block_next_i),
    .app_last_block_next_len_i(app_last_block_next_len_i), .phy_ready_i(phy_ready_i),
    .app_ready_v_o(app_ready_v_o), .phy_ctrl_v_o(phy_ctrl_v_o), .phy_data_o(phy_data_o),
    .phy_start_o(phy_start_o), .phy_idle_o(phy_idle_o), .phy_term_o(phy_term_o),
    .phy_term_len_o(phy_term_len_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ctrl_v;
    logic [15:0] data;
    logic       start;
    logic       idle;
    logic       term;
    logic [3:0] term_len;
  } tx_beat_t;

  typedef struct packed {
    logic        valid;
    logic        cancel;
    logic [15:0] data;
    logic [1:0]  len;
  } rx_beat_t;

  typedef struct packed {
    logic        valid, cancel, ctrl_v, start, term;
    logic [1:0]  keep;
    logic [15:0] data;
    rx_beat_t    exp;
  } rx_vec_t;

  int vectors = 0;
  int miscompares = 0;
  tx_beat_t tx_q[$];
  rx_beat_t rx_q[$];
  rx_vec_t  rx_tab[$];

  localparam tx_beat_t IDLE_B  = '{ctrl_v: 1'b1, data: 16'h0000, start: 1'b0, idle: 1'b1, term: 1'b0, term_len: 4'd0};
  localparam tx_beat_t START_B = '{ctrl_v: 1'b1, data: 16'hD555, start: 1'b1, idle: 1'b0, term: 1'b0, term_len: 4'd0};
  localparam rx_beat_t RX_Z    = '{valid: 1'b0, cancel: 1'b0, data: 16'h0000, len: 2'd0};

  function automatic tx_beat_t data_b(input logic [15:0] d);
    return '{ctrl_v: 1'b0, data: d, start: 1'b0, idle: 1'b0, term: 1'b0, term_len: 4'd0};
  endfunction

  function automatic tx_beat_t term_b(input logic [3:0] len, input logic [15:0] d);
    return '{ctrl_v: 1'b1, data: d, start: 1'b0, idle: 1'b0, term: 1'b1, term_len: len};
  endfunction

  function automatic rx_beat_t rx_b(input logic v, input logic c, input logic [15:0] d, input logic [1:0] l);
    return '{valid: v, cancel: c, data: d, len: l};
  endfunction

  function automatic rx_vec_t vec(input logic v, input logic c, input logic ctl, input logic st,
                                  input logic tm, input logic [1:0] k, input logic [15:0] d,
                                  input rx_beat_t e);
    return '{valid: v, cancel: c, ctrl_v: ctl, start: st, term: tm, keep: k, data: d, exp: e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push this cycle's expected outputs, clock once, then compare against the popped expectations.
  task automatic cyc(input tx_beat_t te_in, input rx_beat_t re_in);
    tx_beat_t te;
    rx_beat_t re;
    tx_q.push_back(te_in);
    rx_q.push_back(re_in);
    @(posedge clk);
    #1;
    if (tx_q.size() > 0) begin
      te = tx_q.pop_front();
      check("phy_ctrl_v_o",   32'(phy_ctrl_v_o),   32'(te.ctrl_v));
      check("phy_data_o",     32'(phy_data_o),     32'(te.data));
      check("phy_start_o",    32'(phy_start_o),    32'(te.start));
      check("phy_idle_o",     32'(phy_idle_o),     32'(te.idle));
      check("phy_term_o",     32'(phy_term_o),     32'(te.term));
      check("phy_term_len_o", 32'(phy_term_len_o), 32'(te.term_len));
    end
    if (rx_q.size() > 0) begin
      re = rx_q.pop_front();
      check("app_valid_o",  32'(app_valid_o),  32'(re.valid));
      check("app_cancel_o", 32'(app_cancel_o), 32'(re.cancel));
      check("app_data_o",   32'(app_data_o),   32'(re.data));
      check("app_len_o",    32'(app_len_o),    32'(re.len));
    end
  endtask

  task automatic clear_rx();
    mac_valid_i = 0; mac_cancel_i = 0; mac_ctrl_v_i = 0; mac_idle_i = 0;
    mac_term_i = 0; mac_start_i = '0; mac_term_keep_i = '0; mac_data_i = '0;
  endtask

  task automatic clear_tx();
    app_early_v_i = 0; app_cancel_i = 0; app_last_i = 0; app_last_block_next_i = 0;
    app_data_i = '0; app_pkt_len_i = '0; app_cs_i = '0; app_len_i = '0;
    app_last_block_next_len_i = '0; phy_ready_i = 1;
  endtask

  task automatic handshake(input logic [15:0] pkt_len);
    app_early_v_i = 1; app_pkt_len_i = pkt_len; app_cs_i = 16'hC5C5;
    #1 check("ready_in_idle", 32'(app_ready_v_o), 32'd1);
    cyc(START_B, RX_Z);
    app_early_v_i = 0;
  endtask

  task automatic send_beat(input logic [15:0] d);
    app_data_i = d;
    cyc(data_b(d), RX_Z);
  endtask

  initial begin
    logic [15:0] d;
    clear_rx();
    clear_tx();
    nreset = 1;

    // Reset values, including the combinational ready held low.
    #1 check("ready_in_reset", 32'(app_ready_v_o), 32'd0);
    cyc(IDLE_B, RX_Z);
    cyc(IDLE_B, RX_Z);
    nreset = 0;
    #1 check("ready_after_reset", 32'(app_ready_v_o), 32'd1);
    cyc(IDLE_B, RX_Z);

    // RX vector table: {valid, cancel, ctrl_v, start, term, keep, data, expected}.
    rx_tab.push_back(vec(1, 0, 1, 0, 0, 2'b00, 16'h0707, RX_Z));                    // idle ctrl beat
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'h5555, RX_Z));                    // data while idle
    rx_tab.push_back(vec(1, 0, 1, 0, 0, 2'b00, 16'h1111, RX_Z));                    // ctrl beat idle
    rx_tab.push_back(vec(1, 0, 1, 1, 0, 2'b00, 16'hD555, RX_Z));                    // start
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'h1234, rx_b(1, 0, 16'h1234, 2)));
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'hABCD, rx_b(1, 0, 16'hABCD, 2)));
    rx_tab.push_back(vec(0, 0, 0, 0, 0, 2'b00, 16'hFFFF, RX_Z));                    // not valid
    rx_tab.push_back(vec(1, 0, 1, 0, 1, 2'b01, 16'h00EF, rx_b(1, 0, 16'h00EF, 1)));
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'h9999, RX_Z));                    // back in idle
    rx_tab.push_back(vec(1, 0, 1, 1, 0, 2'b00, 16'hD555, RX_Z));
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'h1111, rx_b(1, 0, 16'h1111, 2)));
    rx_tab.push_back(vec(1, 1, 0, 0, 0, 2'b00, 16'h2323, rx_b(0, 1, 16'h0000, 0))); // cancel
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'h2222, RX_Z));
    rx_tab.push_back(vec(1, 1, 0, 0, 0, 2'b00, 16'h2424, RX_Z));                    // cancel in idle
    rx_tab.push_back(vec(1, 0, 1, 1, 0, 2'b00, 16'hD555, RX_Z));
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'h3333, rx_b(1, 0, 16'h3333, 2)));
    rx_tab.push_back(vec(1, 0, 1, 1, 0, 2'b00, 16'hD555, rx_b(0, 1, 16'h0000, 0))); // restart
    rx_tab.push_back(vec(1, 0, 0, 0, 0, 2'b00, 16'h4444, rx_b(1, 0, 16'h4444, 2)));
    rx_tab.push_back(vec(1, 0, 1, 0, 1, 2'b00, 16'h5678, RX_Z));                    // empty term
    rx_tab.push_back(vec(1, 0, 1, 1, 0, 2'b00, 16'hD555, RX_Z));
    rx_tab.push_back(vec(1, 0, 1, 0, 1, 2'b11, 16'hBEEF, rx_b(1, 0, 16'hBEEF, 2)));
    rx_tab.push_back(vec(1, 0, 1, 1, 0, 2'b00, 16'hD555, RX_Z));
    rx_tab.push_back(vec(1, 0, 1, 0, 1, 2'b10, 16'hBEEF, rx_b(1, 0, 16'hBE00, 1)));
    foreach (rx_tab[i]) begin
      mac_valid_i = rx_tab[i].valid;   mac_cancel_i = rx_tab[i].cancel;
      mac_ctrl_v_i = rx_tab[i].ctrl_v; mac_start_i = rx_tab[i].start;
      mac_term_i = rx_tab[i].term;     mac_term_keep_i = rx_tab[i].keep;
      mac_data_i = rx_tab[i].data;
      cyc(IDLE_B, rx_tab[i].exp);
    end
    clear_rx();
    cyc(IDLE_B, RX_Z);

    // TX 19-byte frame: start, nine full beats, one-byte terminate.
    handshake(16'd19);
    for (int k = 0; k < 9; k++) begin
      d = {8'(2 * k + 1), 8'(2 * k)};
      app_data_i = d;
      if (k == 0) #1 check("ready_in_start", 32'(app_ready_v_o), 32'd0);
      cyc(data_b(d), RX_Z);
    end
    app_data_i = 16'hAB12; app_last_i = 1; app_len_i = 1;
    cyc(term_b(4'd1, 16'h0012), RX_Z);
    clear_tx();
    #1 check("ready_after_term", 32'(app_ready_v_o), 32'd1);
    cyc(IDLE_B, RX_Z);
    cyc(IDLE_B, RX_Z);

    // Request while the PHY is not ready is not accepted.
    phy_ready_i = 0; app_early_v_i = 1;
    #1 check("ready_phy_low", 32'(app_ready_v_o), 32'd0);
    cyc(IDLE_B, RX_Z);
    phy_ready_i = 1;

    // PHY stall mid-frame: outputs frozen, junk on app inputs ignored, no beat lost.
    handshake(16'd8);
    send_beat(16'h1111);
    send_beat(16'h2222);
    phy_ready_i = 0;
    app_data_i = 16'h3333;
    cyc(data_b(16'h2222), RX_Z);
    app_data_i = 16'hDEAD; app_cancel_i = 1; app_last_i = 1;
    cyc(data_b(16'h2222), RX_Z);
    app_data_i = 16'h3333; app_cancel_i = 0; app_last_i = 0;
    cyc(data_b(16'h2222), RX_Z);
    phy_ready_i = 1;
    send_beat(16'h3333);
    app_data_i = 16'h4455; app_last_i = 1; app_len_i = 2;
    cyc(term_b(4'd2, 16'h4455), RX_Z);
    clear_tx();
    phy_ready_i = 0;
    cyc(term_b(4'd2, 16'h4455), RX_Z);
    phy_ready_i = 1;
    cyc(IDLE_B, RX_Z);

    // Cancel after two beats wins over a simultaneous last.
    handshake(16'd6);
    send_beat(16'hA1A2);
    send_beat(16'hB1B2);
    app_cancel_i = 1; app_last_i = 1; app_len_i = 2; app_data_i = 16'hC1C2;
    cyc(term_b(4'd0, 16'h0000), RX_Z);
    clear_tx();
    #1 check("ready_after_cancel", 32'(app_ready_v_o), 32'd1);
    cyc(IDLE_B, RX_Z);

    // Cancel on the very first beat, then a last beat of length zero.
    handshake(16'd2);
    app_cancel_i = 1; app_data_i = 16'h1357;
    cyc(term_b(4'd0, 16'h0000), RX_Z);
    clear_tx();
    cyc(IDLE_B, RX_Z);
    handshake(16'd2);
    send_beat(16'h2468);
    app_last_i = 1; app_len_i = 0; app_data_i = 16'hFFFF;
    cyc(term_b(4'd0, 16'h0000), RX_Z);
    clear_tx();
    cyc(IDLE_B, RX_Z);

    // Reset in the middle of both a TX and an RX frame.
    mac_valid_i = 1; mac_ctrl_v_i = 1; mac_start_i = 1'b1;
    handshake(16'd10);
    mac_ctrl_v_i = 0; mac_start_i = '0; mac_data_i = 16'h8888;
    app_data_i = 16'h7777;
    cyc(data_b(16'h7777), rx_b(1, 0, 16'h8888, 2));
    nreset = 1;
    app_data_i = 16'h9999; mac_data_i = 16'hAAAA;
    #1 check("ready_mid_reset", 32'(app_ready_v_o), 32'd0);
    cyc(IDLE_B, RX_Z);
    nreset = 0;
    app_data_i = 16'h5A5A; mac_data_i = 16'hBBBB;
    #1 check("ready_post_reset", 32'(app_ready_v_o), 32'd1);
    cyc(IDLE_B, RX_Z);
    clear_rx();
    clear_tx();
    cyc(IDLE_B, RX_Z);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
